wlm_premul: RTL and testbench



---
 rtl/wlm_pkg.sv | 27 ++
 rtl/wlm_premul_pp.sv | 21 ++
 rtl/wlm_premul.sv | 159 +++++++++++++++
 tb/tb_wlm_premul.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wlm_pkg.sv
// Shared definitions for the wlm pre-multiplier.
// Holds the default operand geometry, the controller state type and the
// width helpers that the multiplier uses to size its digits and product.
package wlm_pkg;

    localparam int unsigned LOGQ_DEF  = 60;
    localparam int unsigned LOGQH_DEF = 43;
    localparam int unsigned WORD_DEF  = 17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MUL  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Number of WORD-bit digits needed to cover a logq-bit multiplier.
    function automatic int unsigned wlm_ndig(input int unsigned logq, input int unsigned word);
        return (logq + word - 1) / word;
    endfunction

    // Full product width for two logq-bit operands.
    function automatic int unsigned wlm_prod_w(input int unsigned logq);
        return 2 * logq;
    endfunction

endpackage

// File: rtl/wlm_premul_pp.sv
// Combinational WORD x LOGQ partial-product multiplier.
// Kept separate so synthesis maps it onto DSP blocks and so a pipeline
// stage can be inserted here later without touching the controller.
// Ports:
//   a    LOGQ-bit multiplicand
//   d    WORD-bit digit of the multiplier
//   p_c  LOGQ+WORD-bit unshifted partial product a*d
module wlm_premul_pp #(
    parameter int unsigned LOGQ = 60,
    parameter int unsigned WORD = 17
) (
    input  logic [LOGQ-1:0]      a,
    input  logic [WORD-1:0]      d,
    output logic [LOGQ+WORD-1:0] p_c
);

    localparam int unsigned PW = LOGQ + WORD;

    assign p_c = PW'(a) * PW'(d);

endmodule

// File: rtl/wlm_premul.sv
// Word-serial integer multiplier feeding the wlm C/qH inputs.
// Accepts A, B and qH_in over a valid/ready handshake, multiplies one
// WORD-bit digit of B per cycle into a 2*LOGQ accumulator and presents the
// full product C together with the qH captured for that operation.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready depends on out_ready)
//   A, B, qH_in         multiplicand, multiplier, modulus high part
//   out_valid/out_ready result handshake
//   C, qH               product A*B and the qH_in captured with it
//   op_cnt              completed output transfers, only when the
//                       WLM_PREMUL_CNT_EN macro is defined
module wlm_premul
    import wlm_pkg::*;
#(
    parameter int unsigned LOGQ  = LOGQ_DEF,
    parameter int unsigned LOGQH = LOGQH_DEF,
    parameter int unsigned WORD  = WORD_DEF,
    parameter int unsigned FF_IN = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LOGQ-1:0]     A,
    input  logic [LOGQ-1:0]     B,
    input  logic [LOGQH-1:0]    qH_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*LOGQ-1:0]   C,
    output logic [LOGQH-1:0]    qH
`ifdef WLM_PREMUL_CNT_EN
    ,
    output logic [31:0]         op_cnt
`endif
);

    localparam int unsigned NDIG = wlm_ndig(LOGQ, WORD);
    localparam int unsigned CW   = wlm_prod_w(LOGQ);
    localparam int unsigned BW   = NDIG * WORD;
    localparam int unsigned PW   = LOGQ + WORD;
    localparam int unsigned KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [KW-1:0] K_LAST   = KW'(NDIG - 1);
    localparam state_t        ST_FIRST = (FF_IN != 0) ? ST_LOAD : ST_MUL;

    state_t          state;
    state_t          state_nx;
    logic            cap;
    logic            step;
    logic [LOGQ-1:0] a_q;
    logic [BW-1:0]   b_q;
    logic [LOGQH-1:0] qh_q;
    logic [CW-1:0]   acc;
    logic [KW-1:0]   k;
    logic [PW-1:0]   pp_c;
    logic [CW-1:0]   pp_sh_c;

    // Current digit is always the low WORD bits; b_q shifts down as digits retire.
    wlm_premul_pp #(
        .LOGQ (LOGQ),
        .WORD (WORD)
    ) u_pp (
        .a   (a_q),
        .d   (b_q[WORD-1:0]),
        .p_c (pp_c)
    );

    assign pp_sh_c = CW'(pp_c) << (32'(k) * WORD);

    // A new operand can enter while the finished result leaves.
    assign in_ready = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);

    assign C  = acc;
    assign qH = qh_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_nx = state;
        cap      = 1'b0;
        step     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    cap      = 1'b1;
                    state_nx = ST_FIRST;
                end
            end
            ST_LOAD: begin
                state_nx = ST_MUL;
            end
            ST_MUL: begin
                step = 1'b1;
                if (k == K_LAST) begin
                    state_nx = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (in_valid) begin
                        cap      = 1'b1;
                        state_nx = ST_FIRST;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Operand capture, digit accumulation and registered out_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            qh_q      <= '0;
            acc       <= '0;
            k         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state_nx == ST_HOLD);
            if (cap) begin
                a_q  <= A;
                b_q  <= BW'(B);
                qh_q <= qH_in;
                acc  <= '0;
                k    <= '0;
            end else if (step) begin
                acc <= acc + pp_sh_c;
                b_q <= b_q >> WORD;
                k   <= k + KW'(1);
            end
        end
    end

`ifdef WLM_PREMUL_CNT_EN
    // Completed output transfers, free-running modulo 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_cnt <= '0;
        end else if (out_valid && out_ready) begin
            op_cnt <= op_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wlm_premul.sv
// Self-checking bench for wlm_premul: directed cases with hand-computed
// results plus randomized operands under random backpressure, all compared
// every cycle against a transaction-level model of the multiplier.
module tb_wlm_premul;

    localparam int unsigned LOGQ  = 60;
    localparam int unsigned LOGQH = 43;
    localparam int unsigned WORD  = 17;
    localparam int unsigned FF_IN = 1;
    localparam int unsigned NDIG  = (LOGQ + WORD - 1) / WORD;
    localparam int          LAT   = int'(FF_IN + NDIG);

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [LOGQ-1:0]    a;
    logic [LOGQ-1:0]    b;
    logic [LOGQH-1:0]   qh_in;
    logic               out_valid;
    logic               out_ready;
    logic [2*LOGQ-1:0]  c;
    logic [LOGQH-1:0]   qh;
`ifdef WLM_PREMUL_CNT_EN
    logic [31:0]        op_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    wlm_premul #(
        .LOGQ  (LOGQ),
        .LOGQH (LOGQH),
        .WORD  (WORD),
        .FF_IN (FF_IN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .qH_in     (qh_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (c),
        .qH        (qh)
`ifdef WLM_PREMUL_CNT_EN
        ,
        .op_cnt    (op_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, exp, $time);
        end
    endtask

    // Transaction model: one op in flight, result due LAT cycles after acceptance.
    int               slot = 0;
    bit               busy = 1'b0;
    int               due  = 0;
    logic [2*LOGQ-1:0] m_c  = '0;
    logic [LOGQH-1:0] m_qh = '0;
    bit               just_rst = 1'b0;
    int               xfers = 0;
    bit               m_ev;
    bit               m_er;

    always @(negedge clk) begin
        slot++;
        m_ev = busy && (slot >= due);
        m_er = !busy || (m_ev && out_ready);
        chk("out_valid", 128'(out_valid), 128'(m_ev));
        chk("in_ready", 128'(in_ready), 128'(m_er));
        if (m_ev) begin
            chk("C", 128'(c), 128'(m_c));
            chk("qH", 128'(qh), 128'(m_qh));
        end
        if (just_rst) begin
            chk("C_after_reset", 128'(c), 128'(0));
            chk("qH_after_reset", 128'(qh), 128'(0));
        end
`ifdef WLM_PREMUL_CNT_EN
        chk("op_cnt", 128'(op_cnt), 128'(32'(xfers)));
`endif
        just_rst = 1'b0;
        if (!rst_n) begin
            busy     = 1'b0;
            xfers    = 0;
            just_rst = 1'b1;
        end else begin
            if (m_ev && out_ready) begin
                busy = 1'b0;
                xfers++;
            end
            if (in_valid && m_er) begin
                busy = 1'b1;
                due  = slot + 1 + LAT;
                m_c  = (2*LOGQ)'(a) * (2*LOGQ)'(b);
                m_qh = qh_in;
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [LOGQ-1:0] ta, input logic [LOGQ-1:0] tbv,
                        input logic [LOGQH-1:0] tq);
        int n;
        n        = 0;
        in_valid = 1'b1;
        a        = ta;
        b        = tbv;
        qh_in    = tq;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 128'(in_ready), 128'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts falling edges until out_valid is seen.
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 100);
        if (!out_valid) chk("valid_timeout", 128'(out_valid), 128'(1));
    endtask

    bit rdone = 1'b0;

    initial begin
        int n;
        int s1;
        int s2;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        qh_in     = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Smallest product: latency and single-cycle valid pulse.
        send(60'd1, 60'd1, 43'h7FF);
        wait_valid(n);
        chk("t1_latency", 128'(n - 1), 128'(5));
        chk("t1_C", 128'(c), 128'(1));
        chk("t1_qH", 128'(qh), 128'(43'h7FF));
        @(negedge clk);
        chk("t1_pulse", 128'(out_valid), 128'(0));
        @(posedge clk);
        #1;

        // Largest operands.
        send(60'hFFF_FFFF_FFFF_FFFF, 60'hFFF_FFFF_FFFF_FFFF, 43'h123);
        wait_valid(n);
        chk("t2_C", 128'(c), 128'(120'hFFFFFFFFFFFFFFE000000000000001));
        @(posedge clk);
        #1;

        // Backpressure: result held, no new acceptance.
        out_ready = 1'b0;
        send(60'd3, 60'd5, 43'h55);
        wait_valid(n);
        chk("t3_C", 128'(c), 128'(15));
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a        = 60'd9;
        b        = 60'd9;
        repeat (3) begin
            @(negedge clk);
            chk("t3_C_hold", 128'(c), 128'(15));
            chk("t3_in_ready", 128'(in_ready), 128'(0));
            chk("t3_valid_hold", 128'(out_valid), 128'(1));
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_ready_on_release", 128'(in_ready), 128'(1));
        @(negedge clk);
        chk("t3_transferred", 128'(out_valid), 128'(0));
        @(posedge clk);
        #1;

        // Back-to-back: second op accepted in the transfer cycle.
        send(60'd11, 60'd13, 43'h1);
        s1 = slot;
        send(60'd17, 60'd19, 43'h2);
        s2 = slot;
        chk("t4_accept_spacing", 128'(s2 - s1), 128'(6));
        wait_valid(n);
        chk("t4_latency", 128'(n - 1), 128'(5));
        chk("t4_C", 128'(c), 128'(323));
        @(posedge clk);
        #1;

        // Reset during the second multiply digit.
        send(60'd100, 60'd200, 43'h3);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_valid", 128'(out_valid), 128'(0));
        chk("t5_C", 128'(c), 128'(0));
        chk("t5_in_ready", 128'(in_ready), 128'(1));
`ifdef WLM_PREMUL_CNT_EN
        chk("t5_op_cnt", 128'(op_cnt), 128'(0));
`endif
        @(posedge clk);
        #1;
        send(60'd2, 60'd7, 43'h4);
        wait_valid(n);
        chk("t5_latency", 128'(n - 1), 128'(5));
        chk("t5_C_after", 128'(c), 128'(14));
        @(posedge clk);
        #1;

        // Random operands under random backpressure.
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send(60'({$urandom(), $urandom()}), 60'({$urandom(), $urandom()}),
                         43'({$urandom(), $urandom()}));
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("idle_at_end", 128'(in_ready), 128'(1));
`ifdef WLM_PREMUL_CNT_EN
        chk("final_op_cnt", 128'(op_cnt), 128'(11));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
